// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial sequence detector
// Reloadable pattern, selectable overlap, registered pulse, saturating match count.
module seq_detector_param #(
  parameter int                PAT_LEN      = 4,
  parameter logic [PAT_LEN-1:0] PATTERN_INIT = 4'b1011,
  parameter bit                OVERLAP      = 1'b1,
  parameter int                CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i,
  input  logic               i_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_q, out_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= PATTERN_INIT;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      out_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      out_q     <= out_d;
    end
  end

  // Match evaluation looks at the post-shift history and post-increment fill,
  // so the zeroed history after reset/load can never look like a match.
  always_comb begin
    hist_shift = PAT_LEN'({hist_q, i});
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    hit        = (hist_shift == pattern_q) && (fill_inc == FILL_FULL);
  end

  // Next-state logic
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    out_d     = 1'b0;
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (i_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      out_d  = hit;
      if (hit) begin
        if (!OVERLAP) fill_d = '0;
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    out         = out_q;
    match_count = count_q;
  end

endmodule
